// File: rtl/layer_mem_arbiter.sv
// Round-robin arbiter sharing the layer-memory port between conv engine (r0) and readback (r1).
// Port registers load one cycle after a granted request; read data returns 2 cycles after; no back-pressure beyond gnt.
module layer_mem_arbiter #(
   parameter int AW        = 12,
   parameter int DW        = 13,
   parameter int MAX_BURST = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          r0_req,
   input  logic          r1_req,
   input  logic          r0_lock,
   input  logic          r1_lock,
   input  logic          r0_wr,
   input  logic          r1_wr,
   input  logic          r0_sel,
   input  logic          r1_sel,
   input  logic [AW-1:0] r0_addr,
   input  logic [AW-1:0] r1_addr,
   input  logic [DW-1:0] r0_wdata,
   input  logic [DW-1:0] r1_wdata,
   output logic          r0_gnt,
   output logic          r1_gnt,
   output logic          r0_rvalid,
   output logic          r1_rvalid,
   output logic [DW-1:0] r0_rdata,
   output logic [DW-1:0] r1_rdata,
   output logic          cwr,
   output logic          crd,
   output logic          csel,
   output logic [AW-1:0] caddr_wr,
   output logic [AW-1:0] caddr_rd,
   output logic [DW-1:0] cdata_wr,
   input  logic [DW-1:0] cdata_rd,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   localparam logic [8:0] BURST_LIM = 9'(MAX_BURST);

   state_t        state_q, state_d;
   logic          ptr_q, ptr_d;
   logic [7:0]    burst_cnt_q, burst_cnt_d;
   logic          r0_gnt_q, r0_gnt_d, r1_gnt_q, r1_gnt_d, busy_q, busy_d;
   logic          cwr_q, cwr_d, crd_q, crd_d, csel_q, csel_d;
   logic [AW-1:0] caddr_wr_q, caddr_wr_d, caddr_rd_q, caddr_rd_d;
   logic [DW-1:0] cdata_wr_q, cdata_wr_d;
   logic          rd_pend_q, rd_pend_d, rd_id_q, rd_id_d;
   logic          r0_rvalid_q, r0_rvalid_d, r1_rvalid_q, r1_rvalid_d;

   logic          own_id, own_req, own_lock, other_req, issue, burst_hit;
   logic          iss_wr, iss_sel;
   logic [AW-1:0] iss_addr;
   logic [DW-1:0] iss_wdata;
   logic [7:0]    cnt_inc;
   state_t        other_st;

   always_comb begin
      own_id    = (state_q == OWN1);
      own_req   = own_id ? r1_req   : r0_req;
      own_lock  = own_id ? r1_lock  : r0_lock;
      other_req = own_id ? r0_req   : r1_req;
      iss_wr    = own_id ? r1_wr    : r0_wr;
      iss_sel   = own_id ? r1_sel   : r0_sel;
      iss_addr  = own_id ? r1_addr  : r0_addr;
      iss_wdata = own_id ? r1_wdata : r0_wdata;
      other_st  = own_id ? OWN0 : OWN1;
      issue     = ((state_q == OWN0) && r0_req) || ((state_q == OWN1) && r1_req);
      burst_hit = issue && (({1'b0, burst_cnt_q} + 9'd1) >= BURST_LIM);
      cnt_inc   = (burst_cnt_q == 8'hFF) ? burst_cnt_q : burst_cnt_q + 8'd1;

      state_d     = state_q;
      ptr_d       = ptr_q;
      burst_cnt_d = burst_cnt_q;

      case (state_q)
         IDLE: begin
            if (r0_req || r1_req) begin
               // ptr_q = 1 means r1 is favoured on a tie
               state_d     = ((r0_req && r1_req) ? ptr_q : r1_req) ? OWN1 : OWN0;
               burst_cnt_d = 8'd0;
            end
         end
         default: begin
            if (own_lock) begin
               if (issue) burst_cnt_d = cnt_inc;
            end else if (burst_hit && other_req) begin
               state_d     = other_st;
               burst_cnt_d = 8'd0;
               ptr_d       = ~own_id;
            end else if (!own_req) begin
               state_d     = other_req ? other_st : IDLE;
               burst_cnt_d = 8'd0;
               ptr_d       = ~own_id;
            end else if (issue) begin
               burst_cnt_d = cnt_inc;
            end
         end
      endcase

      r0_gnt_d = (state_d == OWN0);
      r1_gnt_d = (state_d == OWN1);
      busy_d   = (state_d != IDLE);

      cwr_d      = issue && iss_wr;
      crd_d      = issue && !iss_wr;
      csel_d     = issue ? iss_sel : csel_q;
      caddr_wr_d = (issue && iss_wr)  ? iss_addr  : caddr_wr_q;
      caddr_rd_d = (issue && !iss_wr) ? iss_addr  : caddr_rd_q;
      cdata_wr_d = (issue && iss_wr)  ? iss_wdata : cdata_wr_q;

      // Tag travels with the read so it returns to its issuer across handovers
      rd_pend_d   = issue && !iss_wr;
      rd_id_d     = own_id;
      r0_rvalid_d = rd_pend_q && !rd_id_q;
      r1_rvalid_d = rd_pend_q && rd_id_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= 1'b0;
         burst_cnt_q <= 8'd0;
         r0_gnt_q    <= 1'b0;
         r1_gnt_q    <= 1'b0;
         busy_q      <= 1'b0;
         cwr_q       <= 1'b0;
         crd_q       <= 1'b0;
         csel_q      <= 1'b0;
         caddr_wr_q  <= '0;
         caddr_rd_q  <= '0;
         cdata_wr_q  <= '0;
         rd_pend_q   <= 1'b0;
         rd_id_q     <= 1'b0;
         r0_rvalid_q <= 1'b0;
         r1_rvalid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         burst_cnt_q <= burst_cnt_d;
         r0_gnt_q    <= r0_gnt_d;
         r1_gnt_q    <= r1_gnt_d;
         busy_q      <= busy_d;
         cwr_q       <= cwr_d;
         crd_q       <= crd_d;
         csel_q      <= csel_d;
         caddr_wr_q  <= caddr_wr_d;
         caddr_rd_q  <= caddr_rd_d;
         cdata_wr_q  <= cdata_wr_d;
         rd_pend_q   <= rd_pend_d;
         rd_id_q     <= rd_id_d;
         r0_rvalid_q <= r0_rvalid_d;
         r1_rvalid_q <= r1_rvalid_d;
      end
   end

   assign r0_gnt    = r0_gnt_q;
   assign r1_gnt    = r1_gnt_q;
   assign busy      = busy_q;
   assign cwr       = cwr_q;
   assign crd       = crd_q;
   assign csel      = csel_q;
   assign caddr_wr  = caddr_wr_q;
   assign caddr_rd  = caddr_rd_q;
   assign cdata_wr  = cdata_wr_q;
   assign r0_rvalid = r0_rvalid_q;
   assign r1_rvalid = r1_rvalid_q;
   assign r0_rdata  = cdata_rd;
   assign r1_rdata  = cdata_rd;

endmodule
